ef_i2c_line_conditioner: RTL and testbench
==========================================

# ef_i2c_line_conditioner

Pad-side front end for the I2C controller. It synchronizes and deglitches the raw SCL/SDA pad inputs and hands clean levels to the controller's `scl_i`/`sda_i`. From the filtered lines it detects START and STOP conditions and tracks bus-busy state. It also flags stuck-low lines and arbitration loss, so firmware can recover a hung bus.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth per line; legal range ≥ 2.
- `FILTER_LEN`, default 4: consecutive disagreeing samples required before a filtered line toggles; legal range 1–15.
- `TIMEOUT_W`, default 16: width of the stuck-line counters and of `timeout_i`.

Ports:
- `clk_i` in 1: the single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `scl_pad_i` in 1: raw SCL from the pad, asynchronous.
- `sda_pad_i` in 1: raw SDA from the pad, asynchronous.
- `scl_f_o` out 1: filtered SCL, feeds the controller's `scl_i`.
- `sda_f_o` out 1: filtered SDA, feeds the controller's `sda_i`.
- `sda_t_i` in 1: controller SDA tristate; 1 means released.
- `arb_chk_i` in 1: controller is transmitting, so the arbitration check is armed.
- `timeout_i` in `TIMEOUT_W`: stuck-low threshold in clk cycles; 0 disables the check.
- `clr_i` in 1: clears all sticky flags.
- `start_o` out 1: one-cycle pulse on START.
- `stop_o` out 1: one-cycle pulse on STOP.
- `busy_o` out 1: bus busy between START and STOP.
- `scl_stuck_o` out 1: sticky flag, SCL held low too long.
- `sda_stuck_o` out 1: sticky flag, SDA held low too long.
- `arb_lost_o` out 1: sticky flag, arbitration lost.

## Operation
Reset values:
- `scl_f_o` = `sda_f_o` = 1 (bus idle).
- All other outputs 0.
- All counters 0.
- Synchronizer flops reset to 1.

Filter, per line:
- A counter `cnt` runs on the synchronized sample `s`.
- If `s` equals the filtered output, `cnt` clears to 0.
- Otherwise `cnt` increments. When it reaches `FILTER_LEN-1` with `s` still different, the filtered output takes `s` on the next edge and `cnt` clears.
- Any pulse shorter than `FILTER_LEN` clk cycles at the synchronizer output is removed.

Condition detection uses the registered previous values `scl_q` and `sda_q` of the filtered lines:
- START: `scl_q` & `scl_f` & `sda_q` & ~`sda_f`.
- STOP: `scl_q` & `scl_f` & ~`sda_q` & `sda_f`.
- If SCL and SDA change in the same cycle, neither condition fires.

`busy_o`:
- Set on START; cleared on STOP.
- START and STOP cannot be simultaneous by construction.
- A repeated START while busy leaves `busy_o` = 1 and still pulses `start_o`.

Stuck-low detection, per line, independently:
- A low-run counter increments while the filtered line is low and clears when it is high.
- The counter saturates at all-ones.
- The flag sets on the edge where the count equals `timeout_i` and the line is still low.
- `timeout_i` = 0 disables setting the flag; existing flags are held.

Arbitration loss:
- Condition: rising edge of `scl_f` (`~scl_q` & `scl_f`) with `arb_chk_i` = 1, `sda_t_i` = 1 and `sda_f_o` = 0.
- On that condition, `arb_lost_o` sets.

Sticky flags and `clr_i`:
- `clr_i` clears all three sticky flags.
- If a set and `clr_i` occur in the same cycle, set wins.
- `clr_i` does not affect `busy_o` or any counter.

Reset asserted mid-transfer returns the block to idle immediately: `busy_o` = 0 and filtered lines = 1. No STOP pulse is generated.

## Timing
- Pad edge to filtered edge: `SYNC_STAGES` + `FILTER_LEN` cycles, assuming a stable input. With defaults this is 6 cycles.
- Filtered edge to `start_o`/`stop_o`: 1 cycle.
- Filtered edge to `busy_o` change: 1 cycle.
- Rising `scl_f` to `arb_lost_o`: 1 cycle.
- All outputs are registered; there is no combinational pad-to-output path.
- `start_o` and `stop_o` are exactly 1 cycle wide.

## Structure
- Shared package/include `ef_i2c_pkg` holds:
  - localparams for the default `SYNC_STAGES`, `FILTER_LEN` and `TIMEOUT_W`;
  - the flag bit positions `FLAG_SCL_STUCK=0`, `FLAG_SDA_STUCK=1`, `FLAG_ARB_LOST=2`, used by the bus wrapper's RIS map.
- Sub-module `ef_i2c_glitch_filter`: synchronizer plus filter counter for one line, instantiated once for SCL and once for SDA.
- Detection, busy tracking, stuck counters and flags live in the top module.

## Test plan
- Reset check: drive `rst_n` low, then release with pads at 1 → `scl_f_o` = `sda_f_o` = 1, all flags 0, `busy_o` = 0.
- Glitch rejection, defaults: a 3-cycle low pulse on `sda_pad_i` → `sda_f_o` stays 1. A 4-cycle low pulse → `sda_f_o` goes low exactly 6 cycles after the pad edge.
- START/STOP: with SCL high, drop SDA → single `start_o` pulse and `busy_o` = 1. Raise SDA → single `stop_o` pulse and `busy_o` = 0. Dropping SCL and SDA in the same cycle → no pulse.
- Stuck SCL, `timeout_i` = 100: hold SCL low 99 cycles → no flag. Hold 100 cycles → `scl_stuck_o` = 1. Then `clr_i` while SCL is still low → flag clears for 1 cycle, then sets again once the saturated count is still ≥ 100. Expected behaviour here: set wins only when coincident; the flag re-sets because the condition persists.
- Arbitration: `arb_chk_i` = 1, `sda_t_i` = 1, SDA pad held 0, SCL rising → `arb_lost_o` = 1 one cycle after the `scl_f` rise. Repeat with `arb_chk_i` = 0 → no flag.
- Reset mid-transfer: assert `rst_n` low while `busy_o` = 1 → `busy_o` = 0 immediately (asynchronous), no `stop_o` pulse.

Source files
------------

// File: rtl/ef_i2c_pkg.sv
// rtl/ef_i2c_pkg.sv - shared defaults and flag bit positions for the I2C line conditioner
package ef_i2c_pkg;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILTER_LEN  = 4;
   localparam int DEF_TIMEOUT_W   = 16;

   localparam int FLAG_SCL_STUCK  = 0;
   localparam int FLAG_SDA_STUCK  = 1;
   localparam int FLAG_ARB_LOST   = 2;
   localparam int NUM_FLAGS       = 3;
endpackage

// File: rtl/ef_i2c_glitch_filter.sv
// rtl/ef_i2c_glitch_filter.sv - pad synchronizer plus run-length glitch filter for one I2C line
module ef_i2c_glitch_filter
   import ef_i2c_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic pad_i,
   output logic line_o
);
   localparam int CW = 4;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   line_q, line_d;
   logic                   s;

   assign s      = sync_q[SYNC_STAGES-1];
   assign line_o = line_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
      line_d = line_q;
      cnt_d  = cnt_q;
      if (s == line_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
         // FILTER_LEN consecutive disagreeing samples: accept the new level
         line_d = s;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         cnt_q  <= '0;
         line_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end
endmodule

// File: rtl/ef_i2c_line_conditioner.sv
// rtl/ef_i2c_line_conditioner.sv - I2C pad front end: filtered lines, START/STOP, busy and fault flags
module ef_i2c_line_conditioner
   import ef_i2c_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILTER_LEN  = DEF_FILTER_LEN,
   parameter int TIMEOUT_W   = DEF_TIMEOUT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic                 scl_pad_i,
   input  logic                 sda_pad_i,
   output logic                 scl_f_o,
   output logic                 sda_f_o,
   input  logic                 sda_t_i,
   input  logic                 arb_chk_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   input  logic                 clr_i,
   output logic                 start_o,
   output logic                 stop_o,
   output logic                 busy_o,
   output logic                 scl_stuck_o,
   output logic                 sda_stuck_o,
   output logic                 arb_lost_o
);
   logic                 scl_f, sda_f;
   logic                 scl_q, scl_d, sda_q, sda_d;
   logic                 start_q, start_d, stop_q, stop_d, busy_q, busy_d;
   logic [TIMEOUT_W-1:0] scl_lo_q, scl_lo_d, sda_lo_q, sda_lo_d;
   logic [NUM_FLAGS-1:0] flags_q, flags_d, flags_set;
   logic                 tmo_en, scl_over, sda_over;

   ef_i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .pad_i (scl_pad_i),
      .line_o(scl_f)
   );

   ef_i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .pad_i (sda_pad_i),
      .line_o(sda_f)
   );

   always_comb begin
      scl_d   = scl_f;
      sda_d   = sda_f;
      start_d = scl_q & scl_f & sda_q & ~sda_f;
      stop_d  = scl_q & scl_f & ~sda_q & sda_f;
      busy_d  = busy_q;
      if (start_d) begin
         busy_d = 1'b1;
      end else if (stop_d) begin
         busy_d = 1'b0;
      end

      scl_lo_d = scl_f ? '0 : ((&scl_lo_q) ? scl_lo_q : scl_lo_q + TIMEOUT_W'(1));
      sda_lo_d = sda_f ? '0 : ((&sda_lo_q) ? sda_lo_q : sda_lo_q + TIMEOUT_W'(1));

      // a held-over low run re-raises a flag only after clr_i has dropped it
      tmo_en   = |timeout_i;
      scl_over = ~scl_f & tmo_en & (scl_lo_d >= timeout_i);
      sda_over = ~sda_f & tmo_en & (sda_lo_d >= timeout_i);
      flags_set = '0;
      flags_set[FLAG_SCL_STUCK] = scl_over & (~flags_q[FLAG_SCL_STUCK] | (scl_lo_d == timeout_i));
      flags_set[FLAG_SDA_STUCK] = sda_over & (~flags_q[FLAG_SDA_STUCK] | (sda_lo_d == timeout_i));
      flags_set[FLAG_ARB_LOST]  = ~scl_q & scl_f & arb_chk_i & sda_t_i & ~sda_f;

      flags_d = flags_set | (flags_q & {NUM_FLAGS{~clr_i}});
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
         busy_q   <= 1'b0;
         scl_lo_q <= '0;
         sda_lo_q <= '0;
         flags_q  <= '0;
      end else begin
         scl_q    <= scl_d;
         sda_q    <= sda_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         busy_q   <= busy_d;
         scl_lo_q <= scl_lo_d;
         sda_lo_q <= sda_lo_d;
         flags_q  <= flags_d;
      end
   end

   assign scl_f_o     = scl_f;
   assign sda_f_o     = sda_f;
   assign start_o     = start_q;
   assign stop_o      = stop_q;
   assign busy_o      = busy_q;
   assign scl_stuck_o = flags_q[FLAG_SCL_STUCK];
   assign sda_stuck_o = flags_q[FLAG_SDA_STUCK];
   assign arb_lost_o  = flags_q[FLAG_ARB_LOST];
endmodule

// File: tb/tb_ef_i2c_line_conditioner.sv
// tb/tb_ef_i2c_line_conditioner.sv - directed and random checks of the I2C line conditioner
module tb_ef_i2c_line_conditioner;
   localparam int S   = 2;
   localparam int L   = 4;
   localparam int TW  = 16;
   localparam int HL  = 32;
   localparam int SAT = 65535;

   logic          clk_i = 1'b0;
   logic          rst_n = 1'b0;
   logic          scl_pad_i = 1'b1;
   logic          sda_pad_i = 1'b1;
   logic          sda_t_i = 1'b1;
   logic          arb_chk_i = 1'b0;
   logic          clr_i = 1'b0;
   logic [TW-1:0] timeout_i = '0;
   logic          scl_f_o, sda_f_o, start_o, stop_o, busy_o;
   logic          scl_stuck_o, sda_stuck_o, arb_lost_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   ef_i2c_line_conditioner dut (
      .clk_i      (clk_i),
      .rst_n      (rst_n),
      .scl_pad_i  (scl_pad_i),
      .sda_pad_i  (sda_pad_i),
      .scl_f_o    (scl_f_o),
      .sda_f_o    (sda_f_o),
      .sda_t_i    (sda_t_i),
      .arb_chk_i  (arb_chk_i),
      .timeout_i  (timeout_i),
      .clr_i      (clr_i),
      .start_o    (start_o),
      .stop_o     (stop_o),
      .busy_o     (busy_o),
      .scl_stuck_o(scl_stuck_o),
      .sda_stuck_o(sda_stuck_o),
      .arb_lost_o (arb_lost_o)
   );

   // reference model: pad sample history, filtered levels, previous levels, low-run lengths
   bit h_scl[HL];
   bit h_sda[HL];
   bit m_scl, m_sda, m_scl_p, m_sda_p;
   bit m_start, m_stop, m_busy, m_scls, m_sdas, m_arb;
   int lo_scl, lo_sda;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // a filtered line flips once the last L synchronized samples all disagree with it
   function automatic bit filt_next(input bit h[HL], input bit f);
      bit all_diff;
      all_diff = 1'b1;
      for (int i = 0; i < L; i++) if (h[S + i] == f) all_diff = 1'b0;
      return all_diff ? ~f : f;
   endfunction

   function automatic bit stuck_set(input bit line, input int lo, input bit flag, input int tmo);
      return !line && tmo != 0 && lo >= tmo && (!flag || lo == tmo);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < HL; i++) begin
         h_scl[i] = 1'b1;
         h_sda[i] = 1'b1;
      end
      m_scl = 1; m_sda = 1; m_scl_p = 1; m_sda_p = 1;
      m_start = 0; m_stop = 0; m_busy = 0; m_scls = 0; m_sdas = 0; m_arb = 0;
      lo_scl = 0; lo_sda = 0;
   endtask

   task automatic model_edge();
      bit n_scl, n_sda, n_start, n_stop, s_scl, s_sda, s_arb;
      for (int i = HL - 1; i > 0; i--) begin
         h_scl[i] = h_scl[i - 1];
         h_sda[i] = h_sda[i - 1];
      end
      h_scl[0] = scl_pad_i;
      h_sda[0] = sda_pad_i;
      n_scl   = filt_next(h_scl, m_scl);
      n_sda   = filt_next(h_sda, m_sda);
      n_start = m_scl_p && m_scl && m_sda_p && !m_sda;
      n_stop  = m_scl_p && m_scl && !m_sda_p && m_sda;
      lo_scl  = m_scl ? 0 : (lo_scl < SAT ? lo_scl + 1 : lo_scl);
      lo_sda  = m_sda ? 0 : (lo_sda < SAT ? lo_sda + 1 : lo_sda);
      s_scl   = stuck_set(m_scl, lo_scl, m_scls, int'(timeout_i));
      s_sda   = stuck_set(m_sda, lo_sda, m_sdas, int'(timeout_i));
      s_arb   = !m_scl_p && m_scl && arb_chk_i && sda_t_i && !m_sda;
      m_scls  = s_scl || (m_scls && !clr_i);
      m_sdas  = s_sda || (m_sdas && !clr_i);
      m_arb   = s_arb || (m_arb && !clr_i);
      if (n_start) m_busy = 1;
      else if (n_stop) m_busy = 0;
      m_start = n_start;
      m_stop  = n_stop;
      m_scl_p = m_scl;
      m_sda_p = m_sda;
      m_scl   = n_scl;
      m_sda   = n_sda;
   endtask

   task automatic step();
      @(posedge clk_i);
      if (rst_n) model_edge();
      else model_reset();
      #1;
      check("scl_f_o", scl_f_o, m_scl);
      check("sda_f_o", sda_f_o, m_sda);
      check("start_o", start_o, m_start);
      check("stop_o", stop_o, m_stop);
      check("busy_o", busy_o, m_busy);
      check("scl_stuck_o", scl_stuck_o, m_scls);
      check("sda_stuck_o", sda_stuck_o, m_sdas);
      check("arb_lost_o", arb_lost_o, m_arb);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int first, n_start, n_stop, hold;
      bit seen_busy, min_sda;

      model_reset();
      run(3);
      check("rst_scl_f", scl_f_o, 1);
      check("rst_sda_f", sda_f_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_flags", {scl_stuck_o, sda_stuck_o, arb_lost_o, start_o, stop_o}, 0);
      rst_n = 1'b1;
      run(5);

      sda_pad_i = 1'b0;
      run(3);
      sda_pad_i = 1'b1;
      min_sda = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (!sda_f_o) min_sda = 1'b0;
      end
      check("glitch3_sda_f", min_sda, 1);

      first = -1; n_start = 0; n_stop = 0; seen_busy = 1'b0;
      sda_pad_i = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 4) sda_pad_i = 1'b1;
         if (!sda_f_o && first < 0) first = i;
         n_start += int'(start_o);
         n_stop  += int'(stop_o);
         if (busy_o) seen_busy = 1'b1;
      end
      check("glitch4_latency", first, 6);
      check("pulse_start_cnt", n_start, 1);
      check("pulse_stop_cnt", n_stop, 1);
      check("pulse_seen_busy", seen_busy, 1);
      check("pulse_busy_end", busy_o, 0);

      sda_pad_i = 1'b0; run(10);
      check("start_busy", busy_o, 1);
      sda_pad_i = 1'b1; run(10);
      check("stop_busy", busy_o, 0);

      n_start = 0; n_stop = 0;
      scl_pad_i = 1'b0; sda_pad_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         n_start += int'(start_o);
         n_stop  += int'(stop_o);
      end
      check("simul_start_cnt", n_start, 0);
      check("simul_stop_cnt", n_stop, 0);
      scl_pad_i = 1'b1; run(10);
      sda_pad_i = 1'b1; run(10);

      timeout_i = 16'd100;
      scl_pad_i = 1'b0; run(99); scl_pad_i = 1'b1; run(10);
      check("stuck_99", scl_stuck_o, 0);
      scl_pad_i = 1'b0; run(100); scl_pad_i = 1'b1; run(10);
      check("stuck_100", scl_stuck_o, 1);
      clr_i = 1'b1; step(); clr_i = 1'b0;
      check("stuck_clr_high", scl_stuck_o, 0);
      scl_pad_i = 1'b0; run(120);
      check("stuck_hold", scl_stuck_o, 1);
      clr_i = 1'b1; step(); clr_i = 1'b0;
      check("stuck_clr_low", scl_stuck_o, 0);
      step();
      check("stuck_reset", scl_stuck_o, 1);
      scl_pad_i = 1'b1; run(10);
      clr_i = 1'b1; step(); clr_i = 1'b0;
      timeout_i = '0;

      arb_chk_i = 1'b1; sda_t_i = 1'b1;
      scl_pad_i = 1'b0; run(10);
      sda_pad_i = 1'b0; run(10);
      scl_pad_i = 1'b1;
      first = -1;
      for (int i = 1; i <= 20 && first < 0; i++) begin
         step();
         if (scl_f_o) first = i;
      end
      check("arb_scl_rise", first, 6);
      check("arb_before", arb_lost_o, 0);
      step();
      check("arb_lost", arb_lost_o, 1);
      clr_i = 1'b1; step(); clr_i = 1'b0;
      check("arb_clr", arb_lost_o, 0);
      arb_chk_i = 1'b0;
      scl_pad_i = 1'b0; run(10);
      scl_pad_i = 1'b1; run(10);
      check("arb_disarmed", arb_lost_o, 0);
      sda_pad_i = 1'b1; run(10);

      sda_pad_i = 1'b0; run(10);
      check("pre_rst_busy", busy_o, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_lines", {scl_f_o, sda_f_o}, 2'b11);
      check("mid_rst_stop", stop_o, 0);
      model_reset();
      run(3);
      sda_pad_i = 1'b1;
      rst_n = 1'b1;
      run(10);

      for (int seg = 0; seg < 40; seg++) begin
         timeout_i = TW'($urandom_range(0, 40));
         for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 2) == 0) scl_pad_i = ~scl_pad_i;
            if ($urandom_range(0, 2) == 0) sda_pad_i = ~sda_pad_i;
            arb_chk_i = 1'($urandom_range(0, 1));
            sda_t_i   = ($urandom_range(0, 3) != 0);
            clr_i     = ($urandom_range(0, 15) == 0);
            hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60))
                                               : int'($urandom_range(1, 6));
            step();
            clr_i = 1'b0;
            run(hold - 1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
